// File: rtl/instr_encoder.sv
// MIPS instruction encoder: turns mnemonic/field requests into 32-bit words and
// queues them with their byte addresses for an instruction-memory writer.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  output logic        err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  // A transfer happens on a side only in a cycle where both valid and ready are 1;
  // ready never depends on valid, and in_ready never looks at out_ready.
  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             err_q, err_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        push, pop, push_word;

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    unique case (in_op)
      4'd0: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100000};
      4'd1: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100010};
      4'd2: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b101010};
      4'd3: enc_word = {6'b000000, in_rs, 15'b0, 6'b001000};
      4'd4: enc_word = {6'b001110, in_rs, in_rt, in_imm};
      4'd5: enc_word = {6'b000101, in_rs, in_rt, in_imm};
      4'd6: enc_word = {6'b000010, in_target};
      4'd7: enc_word = {6'b000011, in_target};
      4'd8: enc_word = {6'b100011, in_rs, in_rt, in_imm};
      4'd9: enc_word = {6'b101011, in_rs, in_rt, in_imm};
      default: enc_legal = 1'b0;
    endcase
  end

  assign in_ready  = (cnt_q < DEPTH_CNT);
  assign out_valid = (cnt_q != '0);
  assign out_word  = out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign out_addr  = addr_q;
  assign err       = err_q;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign push_word = push & enc_legal;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    err_d    = err_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      addr_d   = BASE_ADDR;
      err_d    = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        addr_d   = addr_q + 32'd4;
      end
      if (push_word) begin
        mem_d[wr_ptr_q] = enc_word;
        wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      // Illegal ops complete the handshake but only leave the sticky flag behind.
      if (push && !enc_legal) err_d = 1'b1;
      cnt_d = cnt_q + CNT_W'(push_word) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= BASE_ADDR;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances (base 0 and base FFFF_FFFC) share stimulus;
// a negedge monitor compares both against an expected-word queue.
module tb_instr_encoder;

  localparam logic [31:0] BASE_W = 32'hFFFF_FFFC;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        reset_n, clr, in_valid, out_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        in_ready, out_valid, err;
  logic [31:0] out_word, out_addr;
  logic        w_in_ready, w_out_valid, w_err;
  logic [31:0] w_out_word, w_out_addr;

  logic [31:0] exp_q[$];
  logic [31:0] drv_exp;
  logic [31:0] off;
  logic        exp_err;
  logic        was_reset;
  logic        armed = 1'b0;
  int          sz;
  int          n_checks = 0;
  int          n_fail   = 0;

  instr_encoder #(.BASE_ADDR(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr), .err(err)
  );

  instr_encoder #(.BASE_ADDR(BASE_W), .DEPTH(DEPTH)) dut_w (
    .clk(clk), .reset_n(reset_n), .clr(clr), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_word(w_out_word), .out_addr(w_out_addr), .err(w_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (armed) begin
      sz = exp_q.size();
      chk("in_ready",    {31'b0, in_ready},    {31'b0, sz < DEPTH});
      chk("w_in_ready",  {31'b0, w_in_ready},  {31'b0, sz < DEPTH});
      chk("out_valid",   {31'b0, out_valid},   {31'b0, sz > 0});
      chk("w_out_valid", {31'b0, w_out_valid}, {31'b0, sz > 0});
      chk("out_addr",    out_addr,   off);
      chk("w_out_addr",  w_out_addr, BASE_W + off);
      chk("err",         {31'b0, err},   {31'b0, exp_err});
      chk("w_err",       {31'b0, w_err}, {31'b0, exp_err});
      if (sz > 0) begin
        chk("out_word",   out_word,   exp_q[0]);
        chk("w_out_word", w_out_word, exp_q[0]);
      end
      if (was_reset) chk("out_word_after_reset", out_word, 32'h0);
    end
    // advance the reference state with the inputs the next rising edge will see
    was_reset = !reset_n;
    if (!reset_n || clr) begin
      exp_q.delete();
      off     = 32'h0;
      exp_err = 1'b0;
    end else begin
      sz = exp_q.size();
      if (sz > 0 && out_ready) begin
        void'(exp_q.pop_front());
        off = off + 32'd4;
      end
      if (in_valid && sz < DEPTH) begin
        if (in_op < 4'd10) exp_q.push_back(drv_exp);
        else exp_err = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic [31:0] exp);
    logic acc;
    int   n;
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
    drv_exp  = exp;
    in_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: op %0d not accepted, got in_ready=0 expected 1", op);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 16'h0;
    in_target = 26'h0; drv_exp = 32'h0; off = 32'h0; exp_err = 1'b0; was_reset = 1'b0;
    @(posedge clk); #1;
    armed = 1'b1;
    idle(2);
    reset_n = 1'b1;

    // encoding sweep; the second word out of dut_w wraps its address to 0
    issue(4'd0, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h00221820);
    issue(4'd1, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h00221822);
    issue(4'd2, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h0022182A);
    issue(4'd3, 5'd31, 5'd0,  5'd0,  16'h0000, 26'h0,       32'h03E00008);
    issue(4'd4, 5'd1,  5'd2,  5'd0,  16'h00FF, 26'h0,       32'h382200FF);
    issue(4'd8, 5'd29, 5'd8,  5'd0,  16'h0004, 26'h0,       32'h8FA80004);
    issue(4'd9, 5'd29, 5'd8,  5'd0,  16'h0004, 26'h0,       32'hAFA80004);
    issue(4'd5, 5'd1,  5'd2,  5'd0,  16'hFFFE, 26'h0,       32'h1422FFFE);
    issue(4'd6, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h0000010, 32'h08000010);
    issue(4'd7, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h0000010, 32'h0C000010);
    // unused fields carry junk that must not leak into the word
    issue(4'd3, 5'd31, 5'd2,  5'd3,  16'h1234, 26'h3FFFFFF, 32'h03E00008);
    issue(4'd6, 5'd7,  5'd9,  5'd11, 16'hBEEF, 26'h0000010, 32'h08000010);
    issue(4'd0, 5'd1,  5'd2,  5'd3,  16'hFFFF, 26'h3FFFFFF, 32'h00221820);
    issue(4'd1, 5'd31, 5'd31, 5'd31, 16'h0000, 26'h0,       32'h03FFF822);
    idle(3);

    // backpressure: two fill the buffer, the third waits until out_ready returns
    do_reset();
    out_ready = 1'b0;
    issue(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221820);
    issue(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221822);
    fork
      issue(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0022182A);
      begin idle(4); out_ready = 1'b1; end
    join
    idle(5);

    // illegal op sets sticky err without emitting or moving the address
    do_reset();
    issue(4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0);
    idle(2);
    issue(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221820);
    idle(3);

    // clr with one word buffered, err set, and a same-cycle push that must vanish
    do_reset();
    issue(4'd4, 5'd1, 5'd2, 5'd0, 16'h00FF, 26'h0, 32'h382200FF);
    issue(4'd7, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010, 32'h0C000010);
    idle(2);
    out_ready = 1'b0;
    issue(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0);
    issue(4'd8, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 32'h8FA80004);
    clr = 1'b1; in_valid = 1'b1; in_op = 4'd0; drv_exp = 32'h00221820;
    idle(1);
    clr = 1'b0; in_valid = 1'b0;
    idle(2);
    out_ready = 1'b1;
    issue(4'd9, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 32'hAFA80004);
    idle(3);

    // reset with a full buffer and a same-cycle push
    out_ready = 1'b0;
    issue(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221820);
    issue(4'd5, 5'd1, 5'd2, 5'd0, 16'hFFFE, 26'h0, 32'h1422FFFE);
    idle(1);
    reset_n = 1'b0; in_valid = 1'b1; in_op = 4'd2; drv_exp = 32'h0022182A;
    idle(1);
    reset_n = 1'b1; in_valid = 1'b0;
    idle(2);
    out_ready = 1'b1;
    issue(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0022182A);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first emitted word.
REQ-002 Parameter DEPTH, default 2: output buffer entries, legal range 2..8.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  reset; synchronous, active-low.
REQ-005 clr  input  1  synchronous flush; active-high.
REQ-006 in_valid  input  1  request fields are valid.
REQ-007 in_ready  output  1  encoder accepts a request this cycle.
REQ-008 in_op  input  4  mnemonic select: 0 add, 1 sub, 2 slt, 3 jr, 4 xori, 5 bne, 6 j, 7 jal, 8 lw, 9 sw; 10-15 illegal.
REQ-009 in_rs, in_rt, in_rd  input  5 each  register fields.
REQ-010 in_imm  input  16  immediate / branch offset.
REQ-011 in_target  input  26  jump target field.
REQ-012 out_valid  output  1  out_word/out_addr are valid.
REQ-013 out_ready  input  1  consumer (instruction-memory writer) takes the word.
REQ-014 out_word  output  32  encoded MIPS instruction.
REQ-015 out_addr  output  32  byte address for out_word.
REQ-016 err  output  1  sticky: an illegal in_op was accepted.

Function
REQ-017 Input handshake SHALL complete in a cycle with in_valid=1 and in_ready=1; in_ready SHALL be 1 exactly when buffer occupancy < DEPTH, independent of out_ready in the same cycle.
REQ-018 Output handshake SHALL complete in a cycle with out_valid=1 and out_ready=1; out_valid SHALL be 1 exactly when occupancy > 0; out_word SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 R-type encoding: add = {6'b000000, rs, rt, rd, 5'b0, 6'b100000}; sub is the same with funct 6'b100010; slt is the same with funct 6'b101010.
REQ-020 jr SHALL encode {6'b000000, rs, 15'b0, 6'b001000}; in_rt and in_rd are ignored.
REQ-021 I-type encoding: {opcode, rs, rt, imm}, with opcodes xori 6'b001110, bne 6'b000101, lw 6'b100011, sw 6'b101011.
REQ-022 J-type encoding: {opcode, target}, with opcodes j 6'b000010 and jal 6'b000011.
REQ-023 Fields not used by an op SHALL be encoded as zero, never copied from the inputs.
REQ-024 Latency: a word accepted in cycle N SHALL be visible on out_word with out_valid=1 in cycle N+1 when the buffer was empty.
REQ-025 Words SHALL leave the buffer in acceptance order (FIFO).
REQ-026 Accepting an illegal op SHALL set err to 1 the next cycle and SHALL NOT enqueue a word or advance the address.
REQ-027 Simultaneous push and pop with 0 < occupancy < DEPTH SHALL leave occupancy unchanged.
REQ-028 Simultaneous push and pop at occupancy 0 is impossible; push alone SHALL raise occupancy to 1.
REQ-029 Address counter: out_addr SHALL be BASE_ADDR + 4 × (output handshakes completed since reset/clr); it SHALL increment by 4 on each output handshake.
REQ-030 The address counter SHALL wrap modulo 2^32 with no flag.
REQ-031 clr=1 SHALL, next cycle, empty the buffer, reset the address counter to BASE_ADDR and clear err; handshakes in the clr cycle SHALL be discarded.

Reset
REQ-032 While reset_n=0 at a rising edge: occupancy 0, out_valid 0, in_ready 1, address counter BASE_ADDR, err 0, out_word 32'h0.
REQ-033 Reset asserted mid-transfer SHALL drop all buffered words and any same-cycle handshake.
REQ-034 reset_n SHALL take priority over clr.

Verification
REQ-035 Encoding sweep: add rs=1 rt=2 rd=3 -> 32'h00221820; sub -> 32'h00221822; slt -> 32'h0022182A; jr rs=31 -> 32'h03E00008.
REQ-036 Encoding sweep: xori rs=1 rt=2 imm=16'h00FF -> 32'h382200FF; lw rs=29 rt=8 imm=4 -> 32'h8FA80004; sw -> 32'hAFA80004; bne imm=16'hFFFE -> 32'h1422FFFE; j target=26'h0000010 -> 32'h08000010; jal -> 32'h0C000010.
REQ-037 Backpressure: hold out_ready=0 and push 3 requests with DEPTH=2 -> in_ready=0 after 2 acceptances; release out_ready -> words emerge in order at out_addr 0, 4, 8.
REQ-038 Illegal op: push in_op=12 -> err=1 next cycle, out_valid stays 0, out_addr stays 0; a following add is emitted at out_addr 0.
REQ-039 Wrap and clr: with BASE_ADDR=32'hFFFF_FFFC, emit two words -> out_addr FFFF_FFFC then 0000_0000; pulse clr with 1 word buffered -> out_valid=0, out_addr=FFFF_FFFC, err=0.
REQ-040 Reset mid-operation: pull reset_n low with the buffer full -> next cycle out_valid=0, in_ready=1, out_word=0.
